result_writeback: RTL

- Return path of the FP arithmetic unit. Accepts 64-bit results from the FPU and packs each pair into one 128-bit data-memory word, {first, second}. Writes the words to sequential data-memory addresses.
- Uses the same word layout the operand-fetch side reads: first result in the A slot [127:64], second in the B slot [63:0].
- Buffers results in a small FIFO. Drives a request/acknowledge write port into data memory. On stop, flushes any half-filled word.

---
 rtl/result_writeback.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/result_writeback.sv
// Packs pairs of 64-bit FPU results into 128-bit {first, second} words and writes them to data memory.
// Optional `RESULT_WB_COUNT_EN adds a saturating completed-write counter output wb_count.
`timescale 1ns/1ps
module result_writeback #(
  parameter int unsigned          ADDR_W     = 13,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop,
  input  logic [63:0]       res,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              flush_done
`ifdef RESULT_WB_COUNT_EN
  ,
  output logic [15:0]       wb_count
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, HALF, WRITE, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [63:0]         fifo_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                push_q;
  logic [63:0]         hi_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [127:0]        wdata_q;
  logic                we_q, busy_q, flush_done_q, stop_done_q;

  logic                fifo_full, fifo_empty, avail, push, pop, ack_fire;
  logic [63:0]         head;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // An entry becomes poppable one cycle after it is written (registered read side).
  assign avail      = (count_q != CW'(push_q));
  assign res_ready  = !rst && !fifo_full && !stop;
  assign push       = res_valid && res_ready;
  assign pop        = avail && ((state_q == IDLE) || (state_q == HALF));
  assign head       = fifo_q[rd_ptr_q];
  assign ack_fire   = we_q && mem_ack;

  always_comb begin
    state_d = state_q;
    count_d = count_q + CW'(push) - CW'(pop);
    unique case (state_q)
      IDLE:  if (avail) state_d = HALF;
      HALF: begin
        if (avail)                   state_d = WRITE;
        else if (stop && fifo_empty) state_d = FLUSH;
      end
      WRITE: if (ack_fire) state_d = IDLE;
      FLUSH: if (ack_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_q       <= 1'b0;
      hi_q         <= '0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      stop_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      push_q       <= push;
      busy_q       <= (count_d != '0) || (state_d != IDLE);
      flush_done_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (!stop) stop_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (avail) begin
            hi_q <= head;
          end else if (stop && fifo_empty && !stop_done_q) begin
            // Nothing to flush: report completion once per stop episode.
            flush_done_q <= 1'b1;
            stop_done_q  <= 1'b1;
          end
        end
        HALF: begin
          if (avail) begin
            wdata_q <= {hi_q, head};
            we_q    <= 1'b1;
          end else if (stop && fifo_empty) begin
            wdata_q <= {hi_q, 64'h0};
            we_q    <= 1'b1;
          end
        end
        WRITE: begin
          if (ack_fire) begin
            we_q   <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        FLUSH: begin
          if (ack_fire) begin
            we_q         <= 1'b0;
            addr_q       <= addr_q + ADDR_W'(1);
            flush_done_q <= 1'b1;
            stop_done_q  <= stop;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign flush_done = flush_done_q;

`ifdef RESULT_WB_COUNT_EN
  logic [15:0] wb_count_q;

  always_ff @(posedge clk) begin
    if (rst)                                      wb_count_q <= '0;
    else if (ack_fire && (wb_count_q != 16'hFFFF)) wb_count_q <= wb_count_q + 16'd1;
  end

  assign wb_count = wb_count_q;
`endif

endmodule
